// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, derived widths and the bit-reverse
// address helper used by both the FFT core and its output reorder buffer.
package fft_pkg;

    localparam int N_DEFAULT        = 3;
    localparam int PTS_LOG2_DEFAULT = 3;
    localparam int DATA_W_DEFAULT   = 2 ** N_DEFAULT;
    localparam int PTS_DEFAULT      = 2 ** PTS_LOG2_DEFAULT;

    // Reverse the low 'bits' bits of 'a'; bits above 'bits' are ignored.
    function automatic int unsigned bitrev(input int unsigned a, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < bits) begin
                r = (r << 1) | ((a >> i) & 32'd1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pp_bank.sv
// One ping-pong bank: a register file with a single write port and an
// asynchronous read port, cleared by reset.
module fft_pp_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: this storage is reset on purpose, so it must stay flops rather than
    // an inferred RAM macro; drop the reset loop if a RAM is ever wanted here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2 ** ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reader.sv
// Ping-pong reorder buffer: frames arrive in FFT (bit-reversed) order and
// leave in natural frequency order, one sample per cycle when unblocked.
module fft_bitrev_reader
    import fft_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int PTS_LOG2 = PTS_LOG2_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [2**N-1:0]   in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [2**N-1:0]   out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_err
);

    localparam int DW  = 2 ** N;
    localparam int PTS = 2 ** PTS_LOG2;

    typedef logic [PTS_LOG2-1:0] addr_t;
    localparam addr_t CNT_LAST = addr_t'(PTS - 1);

    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    addr_t         wr_cnt;
    addr_t         rd_cnt;
    addr_t         rd_addr;
    logic          wr_beat;
    logic          rd_beat;
    logic          wr_wrap;
    logic          rd_wrap;
    logic [DW-1:0] rdata [2];

    // Handshakes depend only on registered flags, so there is no path from
    // out_ready to in_ready.
    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_beat   = in_valid && in_ready;
    assign rd_beat   = out_valid && out_ready;
    assign wr_wrap   = wr_beat && (wr_cnt == CNT_LAST);
    assign rd_wrap   = rd_beat && (rd_cnt == CNT_LAST);
    assign out_last  = out_valid && (rd_cnt == CNT_LAST);
    assign rd_addr   = addr_t'(bitrev(32'(rd_cnt), PTS_LOG2));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_pp_bank #(
            .DATA_W (DW),
            .ADDR_W (PTS_LOG2)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_beat && (wr_bank == 1'(b))),
            .waddr (wr_cnt),
            .wdata (in_data),
            .raddr (rd_addr),
            .rdata (rdata[b])
        );
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = rdata[rd_bank];
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            if (wr_beat) begin
                wr_cnt <= wr_cnt + addr_t'(1);
                if (in_last != (wr_cnt == CNT_LAST)) begin
                    frame_err <= 1'b1;
                end
            end
            if (wr_wrap) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (rd_beat) begin
                rd_cnt <= rd_cnt + addr_t'(1);
            end
            // A write can only fill an empty bank and a read only drains a full
            // one, so these two never target the same flag.
            if (rd_wrap) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Randomized and directed bench for fft_bitrev_reader against a frame-level
// queue model of the reorder buffer.
module tb_fft_bitrev_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: frames in progress, reordered output stream, frame count.
    logic [7:0] cur[$];
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int         m_pending = 0;
    int         m_rd_idx  = 0;
    bit         m_err     = 1'b0;
    bit         last_wbeat;
    bit         last_rbeat;
    int         stalls;

    fft_bitrev_reader #(.N(3), .PTS_LOG2(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int rev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    task automatic model_reset();
        cur.delete();
        exp_q.delete();
        m_pending = 0;
        m_rd_idx  = 0;
        m_err     = 1'b0;
    endtask

    // One clock: compare at negedge, update the model at posedge, return #1 later.
    task automatic step();
        bit         wb;
        bit         rb;
        logic [7:0] e;
        @(negedge clk);
        check("in_ready", in_ready, m_pending < 2);
        check("out_valid", out_valid, m_pending > 0);
        check("frame_err", frame_err, m_err);
        if (m_pending > 0) begin
            e = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
            check("out_data", out_data, e);
            check("out_last", out_last, m_rd_idx == 7);
        end else begin
            check("out_data_idle", out_data, 0);
            check("out_last_idle", out_last, 0);
        end
        wb = in_valid && (m_pending < 2);
        rb = (m_pending > 0) && out_ready;
        if (in_valid && !wb) stalls++;
        if (rb) cap_q.push_back(out_data);
        @(posedge clk);
        if (wb) begin
            cur.push_back(in_data);
            if (in_last != (cur.size() == 8)) m_err = 1'b1;
            if (cur.size() == 8) begin
                for (int k = 0; k < 8; k++) exp_q.push_back(cur[rev3(k)]);
                cur.delete();
                m_pending++;
            end
        end
        if (rb) begin
            void'(exp_q.pop_front());
            m_rd_idx++;
            if (m_rd_idx == 8) begin
                m_rd_idx = 0;
                m_pending--;
            end
        end
        #1;
        last_wbeat = wb;
        last_rbeat = rb;
    endtask

    task automatic wait_accept();
        for (int t = 0; t < 300; t++) begin
            step();
            if (last_wbeat) return;
        end
        check("accept_timeout", 0, 1);
    endtask

    task automatic write_frame(input logic [7:0] base, input int last_pos);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            in_last  = (i == last_pos);
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_err", frame_err, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cap(input string tag, input logic [7:0] exp [8]);
        check({tag, "_count"}, cap_q.size(), 8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
            check(tag, cap_q[i], exp[i]);
        end
    endtask

    initial begin
        logic [7:0] exp35 [8] = '{8'h10, 8'h14, 8'h12, 8'h16, 8'h11, 8'h15, 8'h13, 8'h17};
        logic [7:0] exp40 [8] = '{8'h20, 8'h24, 8'h22, 8'h26, 8'h21, 8'h25, 8'h23, 8'h27};
        int reads;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #2;
        apply_reset();

        // Single frame reordered, out_last on final sample.
        out_ready = 1'b1;
        cap_q.delete();
        write_frame(8'h10, 7);
        drain(12);
        check_cap("frame35", exp35);
        check("frame_err_clean", frame_err, 0);

        // Three back-to-back frames with no stall.
        stalls = 0;
        out_ready = 1'b1;
        write_frame(8'h80, 7);
        write_frame(8'h88, 7);
        write_frame(8'h90, 7);
        check("no_stall", stalls, 0);
        drain(12);

        // Both banks fill; the 17th sample is held off.
        out_ready = 1'b0;
        write_frame(8'h40, 7);
        write_frame(8'h48, 7);
        in_valid = 1'b1;
        in_data  = 8'h50;
        in_last  = 1'b0;
        repeat (4) begin
            step();
            check("stall17", last_wbeat, 0);
        end

        // Eight read beats free one bank; the write lands the following cycle.
        out_ready = 1'b1;
        reads = 0;
        for (int t = 0; t < 50 && reads < 8; t++) begin
            step();
            if (last_rbeat) reads++;
        end
        check("pulse_reads", reads, 8);
        check("no_same_cycle_free", last_wbeat, 0);
        out_ready = 1'b0;
        step();
        check("accept_after_free", last_wbeat, 1);
        for (int i = 1; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h50 + 8'(i);
            in_last  = (i == 7);
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain(30);

        // Early in_last: sticky error, framing unchanged.
        cap_q.delete();
        write_frame(8'h60, 4);
        drain(12);
        check("frame_err_sticky", frame_err, 1);
        check("err_frame_len", cap_q.size(), 8);

        // Reset with a partial frame, then again mid-drain.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h70 + 8'(i);
            in_last  = 1'b0;
            wait_accept();
        end
        apply_reset();
        out_ready = 1'b1;
        write_frame(8'h30, 7);
        repeat (3) step();
        apply_reset();
        cap_q.delete();
        write_frame(8'h20, 7);
        drain(12);
        check_cap("frame40", exp40);

        // Random traffic with correct framing.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = in_valid ? (cur.size() == 7) : 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain(40);
        check("final_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
